// File: rtl/controle_jogo_param.sv
// Genius game control unit. It owns the level, address, LED-step and timer counters.
// Optional lives/retry mechanism is enabled by defining CONTROLE_VIDAS_EN.
module controle_jogo_param #(
  parameter int N_CHAN    = 4,
  parameter int MAX_NIVEL = 16,
  parameter int ADDR_W    = 4,
  parameter int T_LED_ON  = 500,
  parameter int T_LED_OFF = 500,
  parameter int T_TIMEOUT = 3000,
  parameter int VIDAS     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [N_CHAN-1:0] jogada,
  input  logic [N_CHAN-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [N_CHAN-1:0] leds,
  output logic [ADDR_W-1:0] nivel,
  output logic [3:0]        vidas_rest,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  localparam int T_MAX1 = (T_LED_ON > T_LED_OFF) ? T_LED_ON : T_LED_OFF;
  localparam int T_MAX  = (T_MAX1 > T_TIMEOUT) ? T_MAX1 : T_TIMEOUT;
  localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0]     ON_LAST  = TW'(T_LED_ON - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(T_LED_OFF - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(T_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] NIV_LAST = ADDR_W'(MAX_NIVEL - 1);
`ifdef CONTROLE_VIDAS_EN
  localparam logic [3:0]        VID_INIT = 4'(VIDAS);
`else
  localparam logic [3:0]        VID_INIT = 4'd1;
`endif

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    LIGA_LED    = 4'h2,
    DESLIGA_LED = 4'h3,
    AVANCA_LED  = 4'h4,
    AGUARDA     = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    SOLTA       = 4'h8,
    PROX_NIVEL  = 4'h9,
    PERDE_VIDA  = 4'hA,
    ACERTOU     = 4'hC,
    TIMEOUT     = 4'hD,
    ERROU       = 4'hE
  } estado_t;

  estado_t           state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] niv_q, niv_d;
  logic [3:0]        vid_q, vid_d;
  logic [N_CHAN-1:0] jog_q, jog_d;
  logic              err_req, err_to;
  logic              timed;

  always_comb begin
    state_d   = state_q;
    end_d     = end_q;
    niv_d     = niv_q;
    vid_d     = vid_q;
    jog_d     = jog_q;
    err_req   = 1'b0;
    err_to    = 1'b0;
    timed     = 1'b0;
    leds      = '0;
    db_estado = state_q;
    unique0 case (state_q)
      INICIAL:     if (iniciar) state_d = PREPARA;
      PREPARA: begin
        niv_d   = '0;
        end_d   = '0;
        vid_d   = VID_INIT;
        jog_d   = '0;
        state_d = LIGA_LED;
      end
      LIGA_LED: begin
        timed = 1'b1;
        leds  = dado_mem;
        if (timer_q == ON_LAST) state_d = DESLIGA_LED;
      end
      DESLIGA_LED: begin
        timed = 1'b1;
        if (timer_q == OFF_LAST) begin
          if (end_q == niv_q) begin
            end_d   = '0;
            state_d = AGUARDA;
          end else begin
            state_d = AVANCA_LED;
          end
        end
      end
      AVANCA_LED: begin
        end_d   = end_q + ADDR_W'(1);
        state_d = LIGA_LED;
      end
      AGUARDA: begin
        timed = 1'b1;
        // A press in the expiry cycle takes priority over the timeout.
        if (jogada != '0) begin
          state_d = REGISTRA;
        end else if (timer_q == TO_LAST) begin
          err_req = 1'b1;
          err_to  = 1'b1;
        end
      end
      REGISTRA: begin
        jog_d   = jogada;
        state_d = COMPARA;
      end
      COMPARA: begin
        if (jog_q != dado_mem) begin
          err_req = 1'b1;
        end else if (end_q < niv_q) begin
          end_d   = end_q + ADDR_W'(1);
          state_d = SOLTA;
        end else if (niv_q == NIV_LAST) begin
          state_d = ACERTOU;
        end else begin
          state_d = PROX_NIVEL;
        end
      end
      SOLTA:       if (jogada == '0) state_d = AGUARDA;
      PROX_NIVEL: begin
        niv_d   = niv_q + ADDR_W'(1);
        end_d   = '0;
        state_d = LIGA_LED;
      end
      PERDE_VIDA: begin
        end_d = '0;
        if (jogada == '0) state_d = LIGA_LED;
      end
      ACERTOU, TIMEOUT, ERROU: if (iniciar) state_d = INICIAL;
      default: begin
        state_d   = INICIAL;
        db_estado = 4'hB;
      end
    endcase

    if (err_req) begin
`ifdef CONTROLE_VIDAS_EN
      if (vid_q > 4'd1) begin
        vid_d   = vid_q - 4'd1;
        end_d   = '0;
        state_d = PERDE_VIDA;
      end else begin
        vid_d   = 4'd0;
        state_d = err_to ? TIMEOUT : ERROU;
      end
`else
      state_d = err_to ? TIMEOUT : ERROU;
`endif
    end

    // The timer restarts on every state change, so each timed state lasts exactly its budget.
    timer_d = (timed && (state_d == state_q)) ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
      end_q   <= '0;
      niv_q   <= '0;
      vid_q   <= VID_INIT;
      jog_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      end_q   <= end_d;
      niv_q   <= niv_d;
      vid_q   <= vid_d;
      jog_q   <= jog_d;
    end
  end

  assign endereco   = end_q;
  assign nivel      = niv_q;
  assign vidas_rest = vid_q;
  assign acertou    = (state_q == ACERTOU);
  assign errou      = (state_q == ERROU);
  assign timeout    = (state_q == TIMEOUT);
  assign pronto     = acertou | errou | timeout;

endmodule

// File: tb/tb_controle_jogo_param.sv
// Bench for controle_jogo_param: directed game scenarios plus randomized play, checked every
// cycle against a phase/arithmetic model of the game rules.
module tb_controle_jogo_param;
  localparam int N    = 4;
  localparam int MAXN = 2;
  localparam int AW   = 2;
  localparam int TON  = 2;
  localparam int TOFF = 2;
  localparam int TTO  = 5;
  localparam int VID  = 2;
  localparam int P    = TON + TOFF + 1;
`ifdef CONTROLE_VIDAS_EN
  localparam int VID_INIT = VID;
`else
  localparam int VID_INIT = 1;
`endif

  localparam int MD_IDLE = 0, MD_PREP = 1, MD_DISP = 2, MD_WAIT = 3, MD_REG = 4, MD_CMP = 5,
                 MD_SOLTA = 6, MD_NEXT = 7, MD_LIFE = 8, MD_WIN = 9, MD_TO = 10, MD_ERR = 11;

  logic          clock = 1'b0;
  logic          reset, iniciar;
  logic [N-1:0]  jogada;
  logic [N-1:0]  dado_mem;
  logic [AW-1:0] endereco, nivel;
  logic [N-1:0]  leds;
  logic [3:0]    vidas_rest, db_estado;
  logic          pronto, acertou, errou, timeout;
  logic [N-1:0]  rom [4];

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int           m_mode = MD_IDLE, m_t = 0, m_niv = 0, m_end = 0, m_vid = VID_INIT;
  logic [N-1:0] m_jog = '0;

  controle_jogo_param #(
    .N_CHAN(N), .MAX_NIVEL(MAXN), .ADDR_W(AW), .T_LED_ON(TON), .T_LED_OFF(TOFF),
    .T_TIMEOUT(TTO), .VIDAS(VID)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .dado_mem(dado_mem),
    .endereco(endereco), .leds(leds), .nivel(nivel), .vidas_rest(vidas_rest),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  assign dado_mem = rom[endereco];

  always #5 clock = ~clock;

  task automatic model_error(input bit is_to);
`ifdef CONTROLE_VIDAS_EN
    if (m_vid > 1) begin
      m_vid  = m_vid - 1;
      m_end  = 0;
      m_mode = MD_LIFE;
      return;
    end
    m_vid = 0;
`endif
    m_mode = is_to ? MD_TO : MD_ERR;
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = MD_IDLE; m_t = 0; m_niv = 0; m_end = 0; m_vid = VID_INIT; m_jog = '0;
      return;
    end
    case (m_mode)
      MD_IDLE: if (iniciar) m_mode = MD_PREP;
      MD_PREP: begin
        m_niv = 0; m_end = 0; m_vid = VID_INIT; m_jog = '0; m_t = 0; m_mode = MD_DISP;
      end
      MD_DISP: begin
        // Display of level n: n+1 steps of P cycles, minus the final advance slot.
        if (m_t == (m_niv + 1) * P - 2) begin
          m_mode = MD_WAIT; m_t = 0; m_end = 0;
        end else begin
          m_t++;
        end
      end
      MD_WAIT: begin
        if (jogada != 0) m_mode = MD_REG;
        else if (m_t == TTO - 1) model_error(1'b1);
        else m_t++;
      end
      MD_REG: begin m_jog = jogada; m_mode = MD_CMP; end
      MD_CMP: begin
        if (m_jog != rom[m_end]) model_error(1'b0);
        else if (m_end < m_niv) begin m_end++; m_mode = MD_SOLTA; end
        else if (m_niv == MAXN - 1) m_mode = MD_WIN;
        else m_mode = MD_NEXT;
      end
      MD_SOLTA: if (jogada == 0) begin m_mode = MD_WAIT; m_t = 0; end
      MD_NEXT: begin m_niv++; m_end = 0; m_t = 0; m_mode = MD_DISP; end
      MD_LIFE: if (jogada == 0) begin m_t = 0; m_mode = MD_DISP; end
      default: if (iniciar) m_mode = MD_IDLE;
    endcase
  endtask

  function automatic logic [3:0] code_of(input int md);
    case (md)
      MD_IDLE: return 4'h0;  MD_PREP: return 4'h1;  MD_WAIT: return 4'h5;
      MD_REG:  return 4'h6;  MD_CMP:  return 4'h7;  MD_SOLTA: return 4'h8;
      MD_NEXT: return 4'h9;  MD_LIFE: return 4'hA;  MD_WIN:  return 4'hC;
      MD_TO:   return 4'hD;  default: return 4'hE;
    endcase
  endfunction

  // Per-cycle compare against the model
  initial begin
    logic [3:0]    e_st, e_vid;
    logic [AW-1:0] e_end, e_niv;
    logic [N-1:0]  e_leds;
    logic [3:0]    e_fl, a_fl;
    int k, r;
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      e_leds = '0;
      e_end  = AW'(m_end);
      if (m_mode == MD_DISP) begin
        k = m_t / P;
        r = m_t % P;
        e_end = AW'(k);
        if (r < TON) begin e_st = 4'h2; e_leds = rom[k]; end
        else if (r < TON + TOFF) e_st = 4'h3;
        else e_st = 4'h4;
      end else begin
        e_st = code_of(m_mode);
      end
      e_niv = AW'(m_niv);
      e_vid = 4'(m_vid);
      e_fl  = {(m_mode == MD_WIN) || (m_mode == MD_TO) || (m_mode == MD_ERR),
               m_mode == MD_WIN, m_mode == MD_ERR, m_mode == MD_TO};
      a_fl  = {pronto, acertou, errou, timeout};
      checks++;
      if ({db_estado, endereco, leds, nivel, vidas_rest, a_fl} !==
          {e_st, e_end, e_leds, e_niv, e_vid, e_fl}) begin
        failures++;
        $display("FAIL model t=%0t: got st=%h end=%0d leds=%b niv=%0d vid=%0d flags=%b expected st=%h end=%0d leds=%b niv=%0d vid=%0d flags=%b",
                 $time, db_estado, endereco, leds, nivel, vidas_rest, a_fl,
                 e_st, e_end, e_leds, e_niv, e_vid, e_fl);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input int code, input int budget, input string nm);
    for (int i = 0; i < budget && db_estado != 4'(code); i++) tick();
    chk(nm, int'(db_estado), code);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    wait_state(1, 10, "start");
    iniciar = 1'b0;
  endtask

  task automatic count_display(output int n, output int lit);
    n = 0; lit = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (db_estado == 4'h5) break;
      if (db_estado >= 4'h2 && db_estado <= 4'h4) n++;
      if (leds != 0) lit++;
    end
  endtask

  task automatic press(input logic [N-1:0] v);
    jogada = v;
    tick();
    tick();
    chk("press_reaches_compara", int'(db_estado), 7);
    tick();
  endtask

  task automatic count_wait(output int n);
    n = 1;
    for (int i = 0; i < 20 && db_estado == 4'h5; i++) begin
      tick();
      if (db_estado == 4'h5) n++;
    end
  endtask

  initial begin
    int n, lit, pd;
    logic [N-1:0] pv;
    reset = 1'b1; iniciar = 1'b0; jogada = '0;
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
    pd = 0; pv = '0;
    repeat (3) tick();
    chk("reset_state", int'(db_estado), 0);
    chk("reset_vidas", int'(vidas_rest), VID_INIT);
    chk("reset_leds", int'(leds), 0);
    reset = 1'b0;
    tick();

    // Full win
    start_game();
    count_display(n, lit);
    chk("disp_len_l0", n, 4);
    chk("disp_lit_l0", lit, 2);
    press(4'b0001);
    chk("l0_done", int'(db_estado), 9);
    jogada = '0;
    count_display(n, lit);
    chk("disp_len_l1", n, 9);
    press(4'b0001);
    chk("l1_first", int'(db_estado), 8);
    jogada = '0;
    tick();
    press(4'b0010);
    chk("win_acertou", int'(acertou), 1);
    chk("win_pronto", int'(pronto), 1);
    chk("win_nivel", int'(nivel), 1);
    chk("win_vidas", int'(vidas_rest), VID_INIT);
    jogada = '0;

    // Wrong presses
    start_game();
    count_display(n, lit);
    press(4'b0100);
`ifdef CONTROLE_VIDAS_EN
    chk("wrong1_state", int'(db_estado), 10);
    chk("wrong1_vidas", int'(vidas_rest), 1);
    jogada = '0;
    count_display(n, lit);
    chk("replay_lit", lit, 2);
    press(4'b0100);
    chk("wrong2_errou", int'(errou), 1);
    chk("wrong2_vidas", int'(vidas_rest), 0);
`else
    chk("wrong_direct_state", int'(db_estado), 14);
    chk("wrong_direct_errou", int'(errou), 1);
    chk("wrong_direct_vidas", int'(vidas_rest), 1);
`endif
    jogada = '0;

    // Timeout
    start_game();
    count_display(n, lit);
    count_wait(n);
    chk("timeout_window", n, 5);
`ifdef CONTROLE_VIDAS_EN
    chk("timeout1_state", int'(db_estado), 10);
    count_display(n, lit);
    count_wait(n);
    chk("timeout_window2", n, 5);
`endif
    chk("timeout_flag", int'(timeout), 1);
    chk("timeout_pronto", int'(pronto), 1);

    // Press on the last cycle of the window wins over expiry
    start_game();
    count_display(n, lit);
    repeat (4) tick();
    chk("last_cycle_still_waiting", int'(db_estado), 5);
    jogada = 4'b0001;
    tick();
    chk("last_cycle_press", int'(db_estado), 6);
    tick();
    tick();
    chk("last_cycle_next", int'(db_estado), 9);
    jogada = '0;

    // Held button counted once
    count_display(n, lit);
    jogada = 4'b0001;
    repeat (20) tick();
    chk("hold_state", int'(db_estado), 8);
    chk("hold_endereco", int'(endereco), 1);
    jogada = '0;
    tick();
    chk("hold_release", int'(db_estado), 5);
    press(4'b0010);
    chk("hold_win", int'(acertou), 1);
    jogada = '0;

    // Reset during display of level 1
    start_game();
    count_display(n, lit);
    press(4'b0001);
    jogada = '0;
    wait_state(2, 10, "reach_display");
    reset = 1'b1;
    tick();
    chk("midreset_state", int'(db_estado), 0);
    chk("midreset_leds", int'(leds), 0);
    chk("midreset_nivel", int'(nivel), 0);
    chk("midreset_vidas", int'(vidas_rest), VID_INIT);
    reset = 1'b0;
    tick();

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      if (m_mode == MD_IDLE) begin
        for (int i = 0; i < 2; i++)
          rom[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'(1 << $urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 499) == 0);
      if (m_mode == MD_IDLE || m_mode == MD_WIN || m_mode == MD_TO || m_mode == MD_ERR)
        iniciar = ($urandom_range(0, 3) == 0);
      else
        iniciar = ($urandom_range(0, 31) == 0);
      case (m_mode)
        MD_WAIT: begin
          if (m_t == 0) begin
            pd = $urandom_range(0, 6);
            pv = ($urandom_range(0, 9) < 7) ? rom[m_end] : 4'($urandom_range(1, 15));
          end
          jogada = (m_t == pd) ? pv : 4'd0;
        end
        MD_REG:  if ($urandom_range(0, 9) == 0) jogada = 4'($urandom_range(1, 15));
        MD_CMP:  ;
        MD_SOLTA, MD_LIFE: if ($urandom_range(0, 2) == 0) jogada = '0;
        default: jogada = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      endcase
      tick();
    end
    reset = 1'b0; iniciar = 1'b0; jogada = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
